// File: rtl/act_window_regfile.sv
// 3x3 activation window register file. Takes one column per load from banks A/B/C,
// selected per row by codes that are delayed one cycle to line up with the BRAM read data.
module act_window_regfile #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROW_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       act_load,
  input  logic [1:0]                 sel_row0,
  input  logic [1:0]                 sel_row1,
  input  logic [1:0]                 sel_row2,
  input  logic [DATA_W-1:0]          mem_dout_A,
  input  logic [DATA_W-1:0]          mem_dout_B,
  input  logic [DATA_W-1:0]          mem_dout_C,
  input  logic                       flush,
  output logic [9*DATA_W-1:0]        window_out,
  output logic                       window_valid,
  output logic                       row_done,
  output logic [$clog2(ROW_LEN)-1:0] col_cnt_out,
  output logic                       sel_err
);

  localparam int unsigned CntW = $clog2(ROW_LEN);

  localparam logic [1:0] SelZero = 2'd0;
  localparam logic [1:0] SelA    = 2'd1;
  localparam logic [1:0] SelB    = 2'd2;
  localparam logic [1:0] SelC    = 2'd3;

  // Stage 1: load strobe and codes delayed to match the read latency.
  logic            load_dly_q, load_dly_d;
  // Index 2 holds row 0's code, index 0 holds row 2's code.
  logic [2:0][1:0] sel_dly_q, sel_dly_d;

  // Window element (r,c) lives at index 3*r+c; c=0 is the oldest column.
  logic [8:0][DATA_W-1:0] win_q, win_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   row_done_q, row_done_d;
  logic                   err_q, err_d;

  logic [2:0][DATA_W-1:0] col;
  logic                   dup_sel;

  // Column steering from the delayed codes; ZERO forces padding regardless of bank data.
  always_comb begin
    col = '0;
    for (int r = 0; r < 3; r++) begin
      unique case (sel_dly_q[2-r])
        SelZero: col[r] = '0;
        SelA:    col[r] = mem_dout_A;
        SelB:    col[r] = mem_dout_B;
        SelC:    col[r] = mem_dout_C;
        default: col[r] = '0;
      endcase
    end
  end

  // Two rows pulling from the same bank in one load is a controller bug; ZERO may repeat.
  always_comb begin
    dup_sel = ((sel_row0 != SelZero) && ((sel_row0 == sel_row1) || (sel_row0 == sel_row2))) ||
              ((sel_row1 != SelZero) && (sel_row1 == sel_row2));
  end

  // Next-state: shift on a delayed load, count columns, flush overrides everything but sel_err.
  always_comb begin
    load_dly_d = act_load;
    sel_dly_d  = {sel_row0, sel_row1, sel_row2};
    win_d      = win_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    row_done_d = 1'b0;
    err_d      = err_q | (act_load & dup_sel);

    if (load_dly_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
        win_d[3*r+2] = col[r];
      end
      cnt_d      = (cnt_q == CntW'(ROW_LEN - 1)) ? '0 : cnt_q + CntW'(1);
      // Two earlier columns of this pass must already be in place.
      valid_d    = (cnt_q >= CntW'(2));
      row_done_d = (cnt_q == CntW'(ROW_LEN - 1));
    end

    if (flush) begin
      load_dly_d = 1'b0;
      sel_dly_d  = '0;
      win_d      = '0;
      cnt_d      = '0;
      valid_d    = 1'b0;
      row_done_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_dly_q <= 1'b0;
      sel_dly_q  <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      load_dly_q <= load_dly_d;
      sel_dly_q  <= sel_dly_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      row_done_q <= row_done_d;
      err_q      <= err_d;
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign row_done     = row_done_q;
  assign col_cnt_out  = cnt_q;
  assign sel_err      = err_q;

endmodule

// File: doc/act_window_regfile.md
Name: act_window_regfile

Overview:
- Activation register file between activation memory banks A/B/C and the PE array.
- Each load cycle, steers one 3-pixel column out of the banks into a 3x3 sliding window, using the per-row bank-selection codes from the activation controller.
- Selection codes are aligned to the 1-cycle BRAM read latency.
- Handles zero-padding rows (code ZERO), row-pass boundaries, flush between channels/tiles, and flags invalid code timing.

Parameters:
- DATA_W, 8, activation word width in bits.
- ROW_LEN, 16, columns per row pass (load cycles per output row); must be >= 3.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- act_load  input  1  high in the cycle bank addresses/enables are issued (act_mem_to_reg).
- sel_row0  input  2  bank code for window row 0: 0=ZERO, 1=A, 2=B, 3=C.
- sel_row1  input  2  same, window row 1.
- sel_row2  input  2  same, window row 2.
- mem_dout_A  input  DATA_W  bank A read data, valid 1 cycle after address.
- mem_dout_B  input  DATA_W  bank B read data, same timing.
- mem_dout_C  input  DATA_W  bank C read data, same timing.
- flush  input  1  synchronous clear of window and counters.
- window_out  output  9*DATA_W  element (r,c) at [(3*r+c)*DATA_W +: DATA_W]; r = row 0..2, c = 0 oldest column .. 2 newest column.
- window_valid  output  1  window_out holds a complete fresh 3x3 window this cycle.
- row_done  output  1  1-cycle pulse with the last window of a row pass.
- col_cnt_out  output  $clog2(ROW_LEN)  current column count (debug/verification).
- sel_err  output  1  sticky; set when the same bank is selected by two rows in one load cycle.

Behaviour:
- Reset values (async, rst_n low): window_out=0, window_valid=0, row_done=0, col_cnt_out=0, sel_err=0. Internal load_d=0, sel_d=0.
- Stage 1, edge ending cycle t: load_d <= act_load; sel_d <= {sel_row0, sel_row1, sel_row2}.
- Stage 2, cycle t+1 (combinational): column word r = mux(sel_d[r]; ZERO->0, A->mem_dout_A, B->mem_dout_B, C->mem_dout_C). ZERO forces 0 regardless of bank data.
- Stage 2, edge ending t+1, when load_d=1:
  - window shifts: c0 <= c1, c1 <= c2, c2 <= new column.
  - col_cnt increments; wraps ROW_LEN-1 -> 0.
- Latency: act_load at cycle t -> new column visible on window_out at cycle t+2.
- window_valid (registered) = 1 at t+2 iff load_d was 1 at t+1 and pre-increment col_cnt >= 2.
  - Gives ROW_LEN-2 valid windows per row pass (14 for ROW_LEN=16).
- row_done (registered) = 1 in the cycle of the shift with pre-increment col_cnt == ROW_LEN-1. Coincides with the last window_valid of the pass.
- Row wrap: window columns are not cleared. Stale columns are never flagged valid, because col_cnt restarts at 0 and valid needs 2 further shifts.
- Load gaps (act_load low): no shift, col_cnt holds, window_out holds, window_valid=0, row_done=0. A pass may resume mid-row.
- flush: synchronous; highest priority over a pending load_d shift and over act_load. Next cycle: window, col_cnt, load_d, sel_d, window_valid, row_done all 0. sel_err is unaffected.
- Flush mid-row: discards in-flight column (load_d cleared) and partial row.
- sel_err: set when act_load=1 and two sel_row codes are equal and nonzero. Cleared only by reset. Data path still uses the codes as given.
- No backpressure: consumer must accept every window_valid cycle.

Test Plan:
- Reset then 16 consecutive act_load cycles, sel={A,B,C}; A/B/C return 10+k, 20+k, 30+k on load k (k=0..15), data arriving 1 cycle after each load -> window_valid high 14 cycles, first window at cycle 4 after the first load. First window: row0 = {10,11,12}, row1 = {20,21,22}, row2 = {30,31,32}. row_done pulses with the window whose newest column is k=15. col_cnt_out returns to 0.
- Top padding: sel={ZERO,A,B} for 3 loads, bank data 0xFF -> row0 of valid window all 0; rows 1/2 = 0xFF.
- Rotated codes: load with {C,A,B} then {B,C,A} -> column words follow codes 1 cycle later: row0 = C then B data.
- Gaps: 2 loads, 3 idle cycles, 1 load -> window_valid first high 2 cycles after the third load; col_cnt_out=3.
- flush asserted the cycle after the 5th load -> that column is discarded; window_out=0, col_cnt_out=0. Next 2 loads give no valid; the 3rd does.
- sel={A,A,C} with act_load=1 -> sel_err=1 next cycle and stays 1 through flush. rst_n low mid-row -> all outputs 0 immediately.
